// File: rtl/scope_pkg.sv
// Shared types for the sampler playback path.
// Pair encoding and FSM states used by smpl_unpacker.
package scope_pkg;

    typedef enum logic {IDLE, RUN} unpk_state_t;

    localparam int PAIRS_PER_BYTE = 4;

    typedef struct packed {
        logic hi;
        logic lo;
    } smpl_pair_t;

    function automatic smpl_pair_t pick_pair(
        input logic [7:0] b,
        input logic [1:0] k
    );
        return smpl_pair_t'(b[{k, 1'b0} +: 2]);
    endfunction

endpackage

// File: rtl/smpl_byte_buf.sv
// Single-entry pending byte slot with vld/rdy accept side.
// The FSM empties it through take.
module smpl_byte_buf (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       byte_vld,
    output logic       byte_rdy,
    input  logic       take,
    output logic [7:0] data,
    output logic       full
);

    assign byte_rdy = !full;

    // take and accept are exclusive: take needs full, accept needs !full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            full <= 1'b0;
        end else if (take) begin
            full <= 1'b0;
        end else if (byte_vld && !full) begin
            data <= byte_in;
            full <= 1'b1;
        end
    end

endmodule

// File: rtl/smpl_unpacker.sv
// Replays packed capture bytes as 4 time-ordered (High, Low) pairs,
// oldest pair first, one pair per smpl_en strobe.
module smpl_unpacker #(
    parameter logic IDLE_LOW  = 1'b0,
    parameter logic IDLE_HIGH = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       smpl_en,
    input  logic [7:0] byte_in,
    input  logic       byte_vld,
    output logic       byte_rdy,
    output logic       CH_Low_o,
    output logic       CH_High_o,
    output logic       smpl_vld,
    output logic       underrun
);
    import scope_pkg::*;

    localparam logic [1:0] LAST_IDX = 2'(PAIRS_PER_BYTE - 1);
    localparam smpl_pair_t IDLE_PAIR = '{hi: IDLE_HIGH, lo: IDLE_LOW};

    unpk_state_t state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  act_q, act_d;
    smpl_pair_t  pair_q, pair_d;
    logic        vld_q, vld_d;
    logic        unr_q, unr_d;
    logic        run_q;
    logic        take;
    logic [7:0]  pend_data;
    logic        pend_full;

    smpl_byte_buf u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .byte_in  (byte_in),
        .byte_vld (byte_vld),
        .byte_rdy (byte_rdy),
        .take     (take),
        .data     (pend_data),
        .full     (pend_full)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        act_d   = act_q;
        pair_d  = pair_q;
        vld_d   = 1'b0;
        unr_d   = unr_q;
        take    = 1'b0;
        if (run && !run_q) unr_d = 1'b0;
        // run low wins over any strobe; pending byte stays put
        if (!run) begin
            state_d = IDLE;
            idx_d   = '0;
            pair_d  = IDLE_PAIR;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pend_full) begin
                        act_d   = pend_data;
                        take    = 1'b1;
                        idx_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (smpl_en) begin
                        pair_d = pick_pair(act_q, idx_q);
                        vld_d  = 1'b1;
                        idx_d  = idx_q + 2'd1;
                        if (idx_q == LAST_IDX) begin
                            if (pend_full) begin
                                act_d = pend_data;
                                take  = 1'b1;
                            end else begin
                                state_d = IDLE;
                                unr_d   = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            act_q   <= '0;
            pair_q  <= IDLE_PAIR;
            vld_q   <= 1'b0;
            unr_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            act_q   <= act_d;
            pair_q  <= pair_d;
            vld_q   <= vld_d;
            unr_q   <= unr_d;
            run_q   <= run;
        end
    end

    assign CH_High_o = pair_q.hi;
    assign CH_Low_o  = pair_q.lo;
    assign smpl_vld  = vld_q;
    assign underrun  = unr_q;

endmodule

// File: tb/tb_smpl_unpacker.sv
// Randomised and directed bench for smpl_unpacker against a
// queue-based playback model.
module tb_smpl_unpacker;

    localparam logic IDLE_L = 1'b0;
    localparam logic IDLE_H = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       smpl_en = 1'b0;
    logic [7:0] byte_in = '0;
    logic       byte_vld = 1'b0;
    logic       byte_rdy;
    logic       CH_Low_o;
    logic       CH_High_o;
    logic       smpl_vld;
    logic       underrun;

    smpl_unpacker #(.IDLE_LOW(IDLE_L), .IDLE_HIGH(IDLE_H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .smpl_en   (smpl_en),
        .byte_in   (byte_in),
        .byte_vld  (byte_vld),
        .byte_rdy  (byte_rdy),
        .CH_Low_o  (CH_Low_o),
        .CH_High_o (CH_High_o),
        .smpl_vld  (smpl_vld),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model: remaining pairs of the byte being played, one pending byte
    logic [1:0] m_q[$];
    logic [7:0] m_pend;
    bit         m_full, m_play, m_runq, m_vld, m_unr;
    logic [1:0] m_out;

    logic [7:0] tx_q[$];
    logic [1:0] got_q[$];

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        m_q.delete();
        m_full = 0;
        m_play = 0;
        m_runq = 0;
        m_vld  = 0;
        m_unr  = 0;
        m_out  = {IDLE_H, IDLE_L};
    endtask

    task automatic mload();
        for (int k = 0; k < 4; k++) m_q.push_back(m_pend[2*k +: 2]);
        m_full = 0;
    endtask

    task automatic mstep(bit r, bit s, bit bv, logic [7:0] bi);
        bit acc;
        acc = bv && !m_full;
        m_vld = 0;
        if (r && !m_runq) m_unr = 0;
        if (!r) begin
            m_out = {IDLE_H, IDLE_L};
            m_q.delete();
            m_play = 0;
        end else if (!m_play) begin
            if (m_full) begin
                mload();
                m_play = 1;
            end
        end else if (s) begin
            m_out = m_q.pop_front();
            m_vld = 1;
            if (m_q.size() == 0) begin
                if (m_full) mload();
                else begin
                    m_play = 0;
                    m_unr  = 1;
                end
            end
        end
        m_runq = r;
        if (acc) begin
            m_pend = bi;
            m_full = 1;
        end
    endtask

    task automatic tick(bit r, bit s, bit g);
        bit bv;
        logic [7:0] bi;
        bv = g && (tx_q.size() > 0);
        bi = bv ? tx_q[0] : 8'($urandom);
        // junk on the bus while the slot is full must not be captured
        if (bv && m_full) bi = 8'($urandom);
        run = r;
        smpl_en = s;
        byte_vld = bv;
        byte_in = bi;
        @(posedge clk);
        if (bv && !m_full) void'(tx_q.pop_front());
        mstep(r, s, bv, bi);
        @(negedge clk);
        chk("ch_high", 8'(CH_High_o), 8'(m_out[1]));
        chk("ch_low", 8'(CH_Low_o), 8'(m_out[0]));
        chk("smpl_vld", 8'(smpl_vld), 8'(m_vld));
        chk("underrun", 8'(underrun), 8'(m_unr));
        chk("byte_rdy", 8'(byte_rdy), 8'(!m_full));
        if (smpl_vld) got_q.push_back({CH_High_o, CH_Low_o});
    endtask

    task automatic chk_got(string tag, logic [1:0] exp[$]);
        chk({tag, "_cnt"}, 8'(got_q.size()), 8'(exp.size()));
        for (int i = 0; i < exp.size() && i < got_q.size(); i++)
            chk(tag, 8'(got_q[i]), 8'(exp[i]));
        got_q.delete();
    endtask

    initial begin
        logic [1:0] e2[$], e3[$], e4[$];
        mreset();
        repeat (2) @(negedge clk);
        chk("rst_high", 8'(CH_High_o), 8'(IDLE_H));
        chk("rst_low", 8'(CH_Low_o), 8'(IDLE_L));
        chk("rst_vld", 8'(smpl_vld), 8'd0);
        chk("rst_unr", 8'(underrun), 8'd0);
        chk("rst_rdy", 8'(byte_rdy), 8'd1);
        rst_n = 1'b1;

        // idle with no bytes
        for (int i = 0; i < 20; i++) tick(1, i % 4 == 3, 1);
        chk_got("idle_pairs", e2);

        // single byte then starve
        tx_q.push_back(8'hB4);
        for (int i = 0; i < 24; i++) tick(1, i % 4 == 3, 1);
        e2 = '{2'b00, 2'b01, 2'b11, 2'b10};
        chk_got("b4_pairs", e2);
        chk("b4_unr", 8'(underrun), 8'd1);

        // back-to-back bytes, gapless
        tx_q.push_back(8'h1B);
        tx_q.push_back(8'hE4);
        for (int i = 0; i < 40; i++) tick(1, i % 4 == 3, 1);
        e3 = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
        chk_got("b2b_pairs", e3);

        // run dropped mid-byte with a byte pending
        tx_q.push_back(8'hFF);
        tx_q.push_back(8'h00);
        for (int i = 0; i < 8; i++) tick(1, i % 4 == 3, 1);
        tick(0, 1, 1);
        chk("drop_high", 8'(CH_High_o), 8'(IDLE_H));
        chk("drop_low", 8'(CH_Low_o), 8'(IDLE_L));
        tick(1, 0, 1);
        chk("rise_unr", 8'(underrun), 8'd0);
        for (int i = 0; i < 24; i++) tick(1, i % 4 == 3, 1);
        e4 = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        chk_got("drop_pairs", e4);

        // async reset at idx=2 with slot full and underrun set
        tx_q.push_back(8'h6C);
        tx_q.push_back(8'h93);
        for (int i = 0; i < 12; i++) tick(1, i % 4 == 3 && i > 3, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_high", 8'(CH_High_o), 8'(IDLE_H));
        chk("arst_low", 8'(CH_Low_o), 8'(IDLE_L));
        chk("arst_vld", 8'(smpl_vld), 8'd0);
        chk("arst_unr", 8'(underrun), 8'd0);
        chk("arst_rdy", 8'(byte_rdy), 8'd1);
        mreset();
        tx_q.delete();
        got_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (tx_q.size() < 3 && $urandom_range(3) == 0)
                tx_q.push_back(8'($urandom));
            tick($urandom_range(49) != 0, $urandom_range(2) == 0,
                 $urandom_range(1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
